// File: rtl/relu_maxpool_unit_if.sv
// relu_maxpool_unit_if: stream bus around the ReLU / 2x2 max-pool stage.
//   master : producer + consumer side (drives start, relu_en, in_*, pool_ready)
//   slave  : the pooling unit (drives pool_val, pool_valid, frame_done, overflow)
interface relu_maxpool_unit_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              relu_en;
  logic [DATA_W-1:0] in_val;
  logic              in_valid;
  logic [DATA_W-1:0] pool_val;
  logic              pool_valid;
  logic              pool_ready;
  logic              frame_done;
  logic              overflow;

  modport master (
    output start, relu_en, in_val, in_valid, pool_ready,
    input  pool_val, pool_valid, frame_done, overflow
  );

  modport slave (
    input  start, relu_en, in_val, in_valid, pool_ready,
    output pool_val, pool_valid, frame_done, overflow
  );
endinterface

// File: rtl/relu_maxpool_unit.sv
// relu_maxpool_unit: optional ReLU followed by 2x2 stride-2 signed max pooling
// over a raster stream of convolution results, with a 2-entry output FIFO.
//   clock  : rising-edge clock
//   reset  : async active-high, clears all state
//   bus    : slave modport (start, relu_en, in_val/in_valid in;
//            pool_val/pool_valid/pool_ready handshake, frame_done, overflow)
module relu_maxpool_unit #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 4,
  parameter int OUT_H  = 4
) (
  input logic                clock,
  input logic                reset,
  relu_maxpool_unit_if.slave bus
);
  // counters are one bit wider than strictly needed so the pooled-region
  // limits (which can equal OUT_W / OUT_H) are representable
  localparam int CW  = $clog2(OUT_W + 1);
  localparam int RW  = $clog2(OUT_H + 1);
  localparam int LB  = (OUT_W / 2 > 0) ? OUT_W / 2 : 1;
  localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_LIM  = CW'(2 * (OUT_W / 2));
  localparam logic [RW-1:0] ROW_LIM  = RW'(2 * (OUT_H / 2));

  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [DATA_W-1:0] h_q, h_d;
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] lb_q [LB];

  logic [1:0]               cnt_q, cnt_d;
  logic signed [DATA_W-1:0] f0_q, f0_d, f1_q, f1_d;
  logic                     ovf_q, ovf_d;

  logic                     accept, col_last, row_last, in_pool, lb_we, push, pop;
  logic [LBW-1:0]           idx;
  logic signed [DATA_W-1:0] v, hmax, vmax;

  // start wins over a coincident pixel
  assign accept   = bus.in_valid && !bus.start;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  // trailing odd column/row is counted but never pooled
  assign in_pool  = (col_q < COL_LIM) && (row_q < ROW_LIM);
  assign idx      = LBW'(col_q >> 1);

  assign v    = (bus.relu_en && bus.in_val[DATA_W-1]) ? '0 : $signed(bus.in_val);
  assign hmax = (v > h_q) ? v : h_q;
  assign vmax = (hmax > lb_q[idx]) ? hmax : lb_q[idx];

  assign lb_we = accept && in_pool && col_q[0] && !row_q[0];
  assign push  = accept && in_pool && col_q[0] && row_q[0];
  assign pop   = (cnt_q != 2'd0) && bus.pool_ready;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    h_d    = h_q;
    done_d = 1'b0;
    if (accept) begin
      done_d = col_last && row_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (in_pool && !col_q[0]) h_d = v;
    end
    if (bus.start) begin
      col_d  = '0;
      row_d  = '0;
      h_d    = '0;
      done_d = 1'b0;
    end
  end

  // pop is applied before push, so push+pop on a full FIFO never drops
  always_comb begin
    cnt_d = cnt_q;
    f0_d  = f0_q;
    f1_d  = f1_q;
    ovf_d = ovf_q;
    if (push && pop) begin
      if (cnt_q == 2'd2) begin
        f0_d = f1_q;
        f1_d = vmax;
      end else begin
        f0_d = vmax;
      end
    end else if (pop) begin
      f0_d  = f1_q;
      cnt_d = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        f0_d  = vmax;
        cnt_d = 2'd1;
      end else if (cnt_q == 2'd1) begin
        f1_d  = vmax;
        cnt_d = 2'd2;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (bus.start) begin
      cnt_d = 2'd0;
      f0_d  = '0;
      f1_d  = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      h_q    <= '0;
      done_q <= 1'b0;
      cnt_q  <= 2'd0;
      f0_q   <= '0;
      f1_q   <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < LB; i++) lb_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      h_q    <= h_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      f0_q   <= f0_d;
      f1_q   <= f1_d;
      ovf_q  <= ovf_d;
      if (lb_we) lb_q[idx] <= hmax;
    end
  end

  assign bus.pool_valid = (cnt_q != 2'd0);
  assign bus.pool_val   = (cnt_q != 2'd0) ? f0_q : '0;
  assign bus.frame_done = done_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_relu_maxpool_unit.sv
module tb_relu_maxpool_unit;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, relu_en = 1'b0, in_valid = 1'b0, pool_ready = 1'b1;
  logic [7:0] in_val = 8'd0;

  always #5 clk = ~clk;

  relu_maxpool_unit_if #(.DATA_W(8)) b0();
  relu_maxpool_unit_if #(.DATA_W(8)) b1();

  assign b0.start = start;  assign b0.relu_en = relu_en;  assign b0.in_val = in_val;
  assign b0.in_valid = in_valid;  assign b0.pool_ready = pool_ready;
  assign b1.start = start;  assign b1.relu_en = relu_en;  assign b1.in_val = in_val;
  assign b1.in_valid = in_valid;  assign b1.pool_ready = pool_ready;

  relu_maxpool_unit #(.DATA_W(8), .OUT_W(4), .OUT_H(4)) dut0 (.clock(clk), .reset(rst), .bus(b0));
  relu_maxpool_unit #(.DATA_W(8), .OUT_W(5), .OUT_H(5)) dut1 (.clock(clk), .reset(rst), .bus(b1));

  int tests = 0, fails = 0, cyc = 0;
  int got0[$], gc0[$], dn0[$], got1[$], dn1[$], exp_q[$];
  int pix[25];
  bit rl[25];
  int dcyc[25];

  // record pops/done pulses as the coming edge will see them, then advance
  task automatic tick();
    if (b0.pool_valid && pool_ready) begin got0.push_back(int'($signed(b0.pool_val))); gc0.push_back(cyc); end
    if (b0.frame_done) dn0.push_back(cyc);
    if (b1.pool_valid && pool_ready) got1.push_back(int'($signed(b1.pool_val)));
    if (b1.frame_done) dn1.push_back(cyc);
    @(posedge clk); #1; cyc++;
  endtask

  task automatic send(input int v, input bit r);
    in_val = 8'(v); relu_en = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int gapmax);
    for (int i = 0; i < n; i++) begin
      dcyc[i] = cyc;
      send(pix[i], rl[i]);
      repeat ($urandom_range(gapmax, 0)) tick();
    end
  endtask

  task automatic clr();
    got0.delete(); gc0.delete(); dn0.delete(); got1.delete(); dn1.delete(); exp_q.delete();
  endtask

  task automatic rand_frame(input int n, input bit rand_relu);
    for (int i = 0; i < n; i++) begin
      pix[i] = int'($urandom_range(255, 0)) - 128;
      rl[i]  = rand_relu ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  endtask

  // reference: each 2x2 window's max of ReLU'd pixels, windows in raster order
  function automatic void model(input int w, input int h);
    for (int wr = 0; wr < h / 2; wr++)
      for (int wc = 0; wc < w / 2; wc++) begin
        int m = -1000;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            int k = (2 * wr + dr) * w + 2 * wc + dc;
            int p = (rl[k] && pix[k] < 0) ? 0 : pix[k];
            if (p > m) m = p;
          end
        exp_q.push_back(m);
      end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (b0.pool_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", b0.pool_valid); end
    tests++; if (b0.pool_val !== 8'd0) begin fails++; $display("FAIL reset_val got %0d exp 0", b0.pool_val); end
    tests++; if (b0.frame_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", b0.frame_done); end
    tests++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", b0.overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    int wi[4] = '{5, 7, 13, 15};
    clr(); pool_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin pix[i] = i + 1; rl[i] = 1'b1; end
    model(4, 4);
    stream(16, 0);
    repeat (3) tick();
    tests++; if (got0.size() !== 4) begin fails++; $display("FAIL ramp_count got %0d exp 4", got0.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= got0.size() || got0[k] !== exp_q[k] || gc0[k] !== dcyc[wi[k]] + 1) begin
        fails++;
        $display("FAIL ramp_out%0d got %0d@%0d exp %0d@%0d", k, (k < got0.size()) ? got0[k] : -999,
                 (k < gc0.size()) ? gc0[k] : -1, exp_q[k], dcyc[wi[k]] + 1);
      end
    end
    tests++;
    if (dn0.size() !== 1 || dn0[0] !== dcyc[15] + 1) begin
      fails++; $display("FAIL ramp_done got %0d pulses first@%0d exp 1@%0d", dn0.size(),
                        (dn0.size() > 0) ? dn0[0] : -1, dcyc[15] + 1);
    end
  endtask

  task automatic test_neg();
    for (int r = 1; r >= 0; r--) begin
      clr();
      for (int i = 0; i < 16; i++) begin pix[i] = -5; rl[i] = 1'(r); end
      model(4, 4);
      stream(16, 0);
      repeat (3) tick();
      tests++; if (got0.size() !== 4) begin fails++; $display("FAIL neg%0d_count got %0d exp 4", r, got0.size()); end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (k >= got0.size() || got0[k] !== exp_q[k]) begin
          fails++; $display("FAIL neg%0d_out%0d got %0d exp %0d", r, k, (k < got0.size()) ? got0[k] : -999, exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_signed();
    clr();
    rand_frame(16, 1'b0);
    pix[0] = -128; pix[1] = 127; pix[4] = -1; pix[5] = 0;
    pix[2] = -3;   pix[3] = -7;  pix[6] = -2; pix[7] = -9;
    model(4, 4);
    stream(16, 0);
    repeat (3) tick();
    tests++; if (got0.size() !== 4) begin fails++; $display("FAIL signed_count got %0d exp 4", got0.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= got0.size() || got0[k] !== exp_q[k]) begin
        fails++; $display("FAIL signed_out%0d got %0d exp %0d", k, (k < got0.size()) ? got0[k] : -999, exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clr();
    for (int f = 0; f < 3; f++) begin
      rand_frame(16, 1'b1);
      model(4, 4);
      stream(16, 2);
    end
    repeat (4) tick();
    tests++; if (got0.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d exp %0d", got0.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      tests++;
      if (k >= got0.size() || got0[k] !== exp_q[k]) begin
        fails++; $display("FAIL b2b_out%0d got %0d exp %0d", k, (k < got0.size()) ? got0[k] : -999, exp_q[k]);
      end
    end
    tests++; if (dn0.size() !== 3) begin fails++; $display("FAIL b2b_done got %0d exp 3", dn0.size()); end
    tests++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL b2b_ovf got %b exp 0", b0.overflow); end
  endtask

  task automatic test_backpressure();
    int e[3] = '{6, 8, 16};
    clr();
    for (int i = 0; i < 16; i++) begin pix[i] = i + 1; rl[i] = 1'b1; end
    pool_ready = 1'b0;
    stream(14, 0);
    tests++; if (b0.overflow !== 1'b1) begin fails++; $display("FAIL bp_ovf_set got %b exp 1", b0.overflow); end
    tests++;
    if (b0.pool_valid !== 1'b1 || b0.pool_val !== 8'd6) begin
      fails++; $display("FAIL bp_head got %b/%0d exp 1/6", b0.pool_valid, b0.pool_val);
    end
    pool_ready = 1'b1;
    send(pix[14], 1'b1);
    send(pix[15], 1'b1);
    repeat (3) tick();
    tests++; if (got0.size() !== 3) begin fails++; $display("FAIL bp_count got %0d exp 3", got0.size()); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (k >= got0.size() || got0[k] !== e[k]) begin
        fails++; $display("FAIL bp_out%0d got %0d exp %0d", k, (k < got0.size()) ? got0[k] : -999, e[k]);
      end
    end
    tests++; if (b0.overflow !== 1'b1) begin fails++; $display("FAIL bp_ovf_sticky got %b exp 1", b0.overflow); end
    start = 1'b1; tick(); start = 1'b0;
    tests++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL bp_ovf_clear got %b exp 0", b0.overflow); end
  endtask

  task automatic test_start_mid();
    clr();
    rand_frame(5, 1'b0);
    stream(5, 0);
    start = 1'b1; in_valid = 1'b1; in_val = 8'd99; relu_en = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b0;
    rand_frame(16, 1'b1);
    model(4, 4);
    stream(16, 1);
    repeat (3) tick();
    tests++; if (got0.size() !== 4) begin fails++; $display("FAIL start_count got %0d exp 4", got0.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= got0.size() || got0[k] !== exp_q[k]) begin
        fails++; $display("FAIL start_out%0d got %0d exp %0d", k, (k < got0.size()) ? got0[k] : -999, exp_q[k]);
      end
    end
    tests++; if (dn0.size() !== 1) begin fails++; $display("FAIL start_done got %0d exp 1", dn0.size()); end
  endtask

  task automatic test_async_reset();
    clr();
    for (int i = 0; i < 16; i++) begin pix[i] = i + 1; rl[i] = 1'b1; end
    pool_ready = 1'b0;
    stream(9, 0);
    tests++; if (b0.pool_valid !== 1'b1) begin fails++; $display("FAIL areset_pre got %b exp 1", b0.pool_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (b0.pool_valid !== 1'b0) begin fails++; $display("FAIL areset_valid got %b exp 0", b0.pool_valid); end
    tests++; if (b0.pool_val !== 8'd0) begin fails++; $display("FAIL areset_val got %0d exp 0", b0.pool_val); end
    tests++; if (b0.overflow !== 1'b0 || b0.frame_done !== 1'b0) begin
      fails++; $display("FAIL areset_flags got %b/%b exp 0/0", b0.overflow, b0.frame_done);
    end
    #2 rst = 1'b0;
    pool_ready = 1'b1;
    tick();
  endtask

  task automatic test_odd();
    clr();
    rand_frame(25, 1'b1);
    model(5, 5);
    stream(25, 1);
    repeat (4) tick();
    tests++; if (got1.size() !== 4) begin fails++; $display("FAIL odd_count got %0d exp 4", got1.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= got1.size() || got1[k] !== exp_q[k]) begin
        fails++; $display("FAIL odd_out%0d got %0d exp %0d", k, (k < got1.size()) ? got1[k] : -999, exp_q[k]);
      end
    end
    tests++;
    if (dn1.size() !== 1 || dn1[0] !== dcyc[24] + 1) begin
      fails++; $display("FAIL odd_done got %0d pulses first@%0d exp 1@%0d", dn1.size(),
                        (dn1.size() > 0) ? dn1[0] : -1, dcyc[24] + 1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_neg();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_start_mid();
    test_async_reset();
    test_odd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
